// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU function codes and FSM state encoding for alu_seq
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_MUL = 2'b10,
        ALU_DIV = 2'b11
    } alu_fun_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DIV  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operand/result handshake bundle for alu_seq
//
// Groups the operand issue side (IN_*, A, B, ALU_FUN) and the result side
// (OUT_*, ALU_OUT, DIV_BY_ZERO). The ALU itself connects through the slave
// modport; the issuer/consumer connects through the master modport.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic               IN_VALID;
    logic               IN_READY;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [1:0]         ALU_FUN;
    logic               OUT_VALID;
    logic               OUT_READY;
    logic [2*WIDTH-1:0] ALU_OUT;
    logic               DIV_BY_ZERO;

    modport master (
        output IN_VALID, A, B, ALU_FUN, OUT_READY,
        input  IN_READY, OUT_VALID, ALU_OUT, DIV_BY_ZERO
    );

    modport slave (
        input  IN_VALID, A, B, ALU_FUN, OUT_READY,
        output IN_READY, OUT_VALID, ALU_OUT, DIV_BY_ZERO
    );
endinterface

// File: rtl/alu_div_iter.sv
// rtl/alu_div_iter.sv - iterative restoring divider, one quotient bit per cycle
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               load dividend/divisor and begin WIDTH iterations
//   dividend, divisor   unsigned operands (divisor must be non-zero)
//   done                high during the final iteration cycle
//   quotient, remainder result of the current iteration; final when done=1
module alu_div_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    logic             busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] den_q, den_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

    always_comb begin
        // Shift the next dividend bit (MSB first) into the partial remainder
        // and try subtracting the divisor; a set top bit of diff means it
        // went negative, so the old remainder is restored.
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, den_q};
        if (!diff[WIDTH]) begin
            step_rem = diff[WIDTH-1:0];
            step_quo = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            step_rem = shifted[WIDTH-1:0];
            step_quo = {quo_q[WIDTH-2:0], 1'b0};
        end

        busy_d = busy_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        den_d  = den_q;
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            rem_d  = '0;
            quo_d  = dividend;
            den_d  = divisor;
        end else if (busy_q) begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_STEP) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            den_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            den_q  <= den_d;
        end
    end

    // The final step result is handed out combinationally so the parent can
    // register it on the same edge the last iteration completes.
    assign done      = busy_q && (cnt_q == LAST_STEP);
    assign quotient  = step_quo;
    assign remainder = step_rem;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - WIDTH-bit ADD/SUB/MUL/DIV unit with valid/ready handshakes
//
// Ports:
//   CLK    rising-edge clock
//   RST_N  asynchronous active-low reset
//   bus    alu_seq_if slave: IN_VALID/IN_READY/A/B/ALU_FUN operand side,
//          OUT_VALID/OUT_READY/ALU_OUT/DIV_BY_ZERO result side
// ADD/SUB/MUL and divide-by-zero load the result register on the accept edge;
// a non-zero divide runs the iterative divider for WIDTH cycles first.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic     CLK,
    input  logic     RST_N,
    alu_seq_if.slave bus
);
    localparam int RW = 2 * WIDTH;

    alu_state_e       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [RW-1:0]    alu_out_q, alu_out_d;
    logic             dbz_q, dbz_d;

    logic             accept;
    logic             div_start;
    logic             div_done;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;
    logic [RW-1:0]    a_ext;
    logic [RW-1:0]    b_ext;

    assign a_ext = {{WIDTH{1'b0}}, bus.A};
    assign b_ext = {{WIDTH{1'b0}}, bus.B};

    // A new op may enter only when idle and the output slot is empty or being
    // drained on this same edge, which gives one op per cycle under no stall.
    assign bus.IN_READY = (state_q == ST_IDLE) && (!out_valid_q || bus.OUT_READY);
    assign accept       = bus.IN_VALID && bus.IN_READY;

    alu_div_iter #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk      (CLK),
        .rst_n    (RST_N),
        .start    (div_start),
        .dividend (bus.A),
        .divisor  (bus.B),
        .done     (div_done),
        .quotient (div_quo),
        .remainder(div_rem)
    );

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q && !bus.OUT_READY;
        alu_out_d   = alu_out_q;
        dbz_d       = dbz_q;
        div_start   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (alu_fun_e'(bus.ALU_FUN))
                        ALU_ADD: begin
                            alu_out_d   = a_ext + b_ext;
                            dbz_d       = 1'b0;
                            out_valid_d = 1'b1;
                        end
                        ALU_SUB: begin
                            alu_out_d   = a_ext - b_ext;
                            dbz_d       = 1'b0;
                            out_valid_d = 1'b1;
                        end
                        ALU_MUL: begin
                            alu_out_d   = a_ext * b_ext;
                            dbz_d       = 1'b0;
                            out_valid_d = 1'b1;
                        end
                        ALU_DIV: begin
                            if (bus.B == '0) begin
                                // remainder = A, quotient = all ones
                                alu_out_d   = {bus.A, {WIDTH{1'b1}}};
                                dbz_d       = 1'b1;
                                out_valid_d = 1'b1;
                            end else begin
                                div_start = 1'b1;
                                state_d   = ST_DIV;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    alu_out_d   = {div_rem, div_quo};
                    dbz_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            alu_out_q   <= alu_out_d;
            dbz_q       <= dbz_d;
        end
    end

    assign bus.OUT_VALID   = out_valid_q;
    assign bus.ALU_OUT     = alu_out_q;
    assign bus.DIV_BY_ZERO = dbz_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq at WIDTH 4, 8 and 16
module tb_alu_seq;
    import alu_pkg::*;

    logic CLK;
    logic RST_N;
    int   checks = 0;
    int   errors = 0;

    logic [8:0]  q4[$];
    logic [16:0] q8[$];
    logic [32:0] q16[$];

    alu_seq_if #(.WIDTH(4))  if4();
    alu_seq_if #(.WIDTH(8))  if8();
    alu_seq_if #(.WIDTH(16)) if16();

    alu_seq #(.WIDTH(4))  u_dut4  (.CLK(CLK), .RST_N(RST_N), .bus(if4));
    alu_seq #(.WIDTH(8))  u_dut8  (.CLK(CLK), .RST_N(RST_N), .bus(if8));
    alu_seq #(.WIDTH(16)) u_dut16 (.CLK(CLK), .RST_N(RST_N), .bus(if16));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] mk(input logic d, input logic [31:0] v);
        return {d, v};
    endfunction

    // Reference model: {div_by_zero, result} using native / and %.
    function automatic logic [32:0] model(input int w, input logic [1:0] f,
                                          input logic [15:0] a_in, input logic [15:0] b_in);
        logic [15:0] wm;
        logic [31:0] mask, r, a, b;
        wm   = (w == 16) ? 16'hFFFF : 16'((32'd1 << w) - 1);
        mask = (w == 16) ? 32'hFFFF_FFFF : ((32'd1 << (2 * w)) - 1);
        a    = {16'd0, a_in & wm};
        b    = {16'd0, b_in & wm};
        case (f)
            2'b00: r = a + b;
            2'b01: r = a - b;
            2'b10: r = a * b;
            default: begin
                if (b == 0) return {1'b1, ((a << w) | {16'd0, wm}) & mask};
                r = ((a % b) << w) | (a / b);
            end
        endcase
        return {1'b0, r & mask};
    endfunction

    task automatic drive(input int w, input logic v, input logic [1:0] f,
                         input logic [15:0] a, input logic [15:0] b);
        case (w)
            4:  begin if4.IN_VALID = v;  if4.ALU_FUN = f;  if4.A = a[3:0];  if4.B = b[3:0];  end
            8:  begin if8.IN_VALID = v;  if8.ALU_FUN = f;  if8.A = a[7:0];  if8.B = b[7:0];  end
            default: begin if16.IN_VALID = v; if16.ALU_FUN = f; if16.A = a; if16.B = b; end
        endcase
    endtask

    task automatic set_out_ready(input int w, input logic v);
        case (w)
            4:  if4.OUT_READY = v;
            8:  if8.OUT_READY = v;
            default: if16.OUT_READY = v;
        endcase
    endtask

    function automatic logic in_ready(input int w);
        case (w)
            4:  return if4.IN_READY;
            8:  return if8.IN_READY;
            default: return if16.IN_READY;
        endcase
    endfunction

    function automatic int qsize(input int w);
        case (w)
            4:  return q4.size();
            8:  return q8.size();
            default: return q16.size();
        endcase
    endfunction

    task automatic push(input int w, input logic [32:0] exp);
        case (w)
            4:  q4.push_back({exp[32], exp[7:0]});
            8:  q8.push_back({exp[32], exp[15:0]});
            default: q16.push_back(exp);
        endcase
    endtask

    // Called #1 after a rising edge; returns #1 after the accept edge.
    // n = cycles spent waiting for IN_READY.
    task automatic issue(input int w, input logic [1:0] f, input logic [15:0] a,
                         input logic [15:0] b, input logic [32:0] exp,
                         input logic do_push, output int n);
        n = 0;
        drive(w, 1'b1, f, a, b);
        @(negedge CLK);
        while (!in_ready(w) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("accept", in_ready(w), 1);
        if (in_ready(w) && do_push) push(w, exp);
        @(posedge CLK);
        #1;
        drive(w, 1'b0, f, a, b);
    endtask

    task automatic random_run(input int w, input int nops);
        int sent = 0;
        int cyc = 0;
        logic v = 1'b0;
        logic [1:0] f = 2'b00;
        logic [15:0] a = '0;
        logic [15:0] b = '0;
        while (sent < nops && cyc < 5000) begin
            @(negedge CLK);
            cyc++;
            if (v && in_ready(w)) begin
                push(w, model(w, f, a, b));
                sent++;
                v = 1'b0;
            end
            @(posedge CLK);
            #1;
            set_out_ready(w, $urandom_range(0, 3) != 0);
            if (!v && sent < nops && $urandom_range(0, 3) != 0) begin
                v = 1'b1;
                f = 2'($urandom_range(0, 3));
                a = 16'($urandom_range(0, (1 << w) - 1));
                b = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(0, (1 << w) - 1));
            end
            drive(w, v, f, a, b);
        end
        drive(w, 1'b0, f, a, b);
        check("random_sent", sent, nops);
        set_out_ready(w, 1'b1);
        cyc = 0;
        while (qsize(w) != 0 && cyc < 200) begin
            @(posedge CLK);
            cyc++;
        end
        #1;
        check("random_drain_empty", qsize(w), 0);
    endtask

    // Scoreboard monitor: pops one expectation per output handshake.
    initial begin
        logic [8:0]  e4;
        logic [16:0] e8;
        logic [32:0] e16;
        forever begin
            @(negedge CLK);
            if (RST_N && if4.OUT_VALID && if4.OUT_READY) begin
                if (q4.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL w4_unexpected: got %0h expected no output", if4.ALU_OUT);
                end else begin
                    e4 = q4.pop_front();
                    check("w4_result", {if4.DIV_BY_ZERO, if4.ALU_OUT}, e4);
                end
            end
            if (RST_N && if8.OUT_VALID && if8.OUT_READY) begin
                if (q8.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL w8_unexpected: got %0h expected no output", if8.ALU_OUT);
                end else begin
                    e8 = q8.pop_front();
                    check("w8_result", {if8.DIV_BY_ZERO, if8.ALU_OUT}, e8);
                end
            end
            if (RST_N && if16.OUT_VALID && if16.OUT_READY) begin
                if (q16.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL w16_unexpected: got %0h expected no output", if16.ALU_OUT);
                end else begin
                    e16 = q16.pop_front();
                    check("w16_result", {if16.DIV_BY_ZERO, if16.ALU_OUT}, e16);
                end
            end
        end
    end

    initial begin
        int n;
        int hi;
        RST_N = 1'b1;
        drive(4, 1'b0, 2'b00, 16'd0, 16'd0);
        drive(8, 1'b0, 2'b00, 16'd0, 16'd0);
        drive(16, 1'b0, 2'b00, 16'd0, 16'd0);
        set_out_ready(4, 1'b1);
        set_out_ready(8, 1'b1);
        set_out_ready(16, 1'b1);
        #2 RST_N = 1'b0;
        @(negedge CLK);
        check("rst_out_valid", if8.OUT_VALID, 0);
        check("rst_alu_out", if8.ALU_OUT, 0);
        check("rst_dbz", if8.DIV_BY_ZERO, 0);
        check("rst_in_ready", if8.IN_READY, 1);
        @(posedge CLK);
        #1 RST_N = 1'b1;

        // W=4 back-to-back single-cycle ops
        issue(4, ALU_ADD, 16'd9, 16'd8, mk(1'b0, 32'h11), 1'b1, n);
        check("t1_add_wait", n, 0);
        issue(4, ALU_SUB, 16'd3, 16'd5, mk(1'b0, 32'hFE), 1'b1, n);
        check("t1_sub_wait", n, 0);
        issue(4, ALU_MUL, 16'd15, 16'd15, mk(1'b0, 32'hE1), 1'b1, n);
        check("t1_mul_wait", n, 0);

        // W=8 divide latency and IN_READY low while dividing
        issue(8, ALU_DIV, 16'd200, 16'd7, mk(1'b0, 32'h041C), 1'b1, n);
        n  = 0;
        hi = 0;
        do begin
            @(negedge CLK);
            n++;
            if (!if8.OUT_VALID && if8.IN_READY) hi++;
        end while (!if8.OUT_VALID && n < 40);
        check("t2_div_latency", n, 9);
        check("t2_in_ready_low", hi, 0);
        @(posedge CLK);
        #1;

        // divide by zero then a plain add clears the flag
        issue(8, ALU_DIV, 16'd37, 16'd0, mk(1'b1, 32'h25FF), 1'b1, n);
        @(negedge CLK);
        check("t3_dbz_latency", if8.OUT_VALID, 1);
        check("t3_dbz_flag", if8.DIV_BY_ZERO, 1);
        @(posedge CLK);
        #1;
        issue(8, ALU_ADD, 16'd1, 16'd1, mk(1'b0, 32'h0002), 1'b1, n);
        @(posedge CLK);
        #1;

        // backpressure
        set_out_ready(8, 1'b0);
        issue(8, ALU_MUL, 16'd12, 16'd12, mk(1'b0, 32'h0090), 1'b1, n);
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            check("t4_hold_valid", if8.OUT_VALID, 1);
            check("t4_hold_out", if8.ALU_OUT, 16'h0090);
            check("t4_in_ready_low", if8.IN_READY, 0);
            @(posedge CLK);
            #1;
        end
        set_out_ready(8, 1'b1);
        issue(8, ALU_ADD, 16'd3, 16'd4, mk(1'b0, 32'h0007), 1'b1, n);
        check("t4_same_edge_accept", n, 0);
        @(posedge CLK);
        #1;

        // reset in the middle of a divide
        issue(8, ALU_DIV, 16'd255, 16'd3, mk(1'b0, 32'h0055), 1'b0, n);
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b0;
        #1;
        check("t5_rst_out_valid", if8.OUT_VALID, 0);
        check("t5_rst_alu_out", if8.ALU_OUT, 0);
        @(posedge CLK);
        #1 RST_N = 1'b1;
        hi = 0;
        repeat (15) begin
            @(negedge CLK);
            if (if8.OUT_VALID) hi++;
        end
        check("t5_no_result", hi, 0);
        check("t5_in_ready", if8.IN_READY, 1);
        @(posedge CLK);
        #1;

        // random traffic against the reference model
        random_run(4, 40);
        random_run(16, 30);

        repeat (3) @(posedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
